// File: rtl/pe_inject_arb.sv
// pe_inject_arb: round-robin injection arbiter with replay-on-resend for one
// BFT leaf port, plus a registered receive path and tx/rx statistics.
module pe_inject_arb #(
   parameter int num_leaves = 256,
   parameter int payload_sz = 23,
   parameter int p_sz       = 32,
   parameter int num_req    = 4,
   parameter int max_retry  = 255
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [num_req-1:0]          req_valid,
   input  logic [num_req*(p_sz-1)-1:0] req_data,
   output logic [num_req-1:0]          req_ready,
   output logic [p_sz-1:0]             pe_interface,
   input  logic [p_sz-1:0]             interface_pe,
   input  logic                        resend,
   output logic [p_sz-2:0]             rx_data,
   output logic                        rx_valid,
   output logic [31:0]                 tx_count,
   output logic [31:0]                 rx_count,
   output logic                        stall
);

   localparam int ADDR_W = $clog2(num_leaves);
   localparam int BODY_W = p_sz - 1;
   localparam int PTR_W  = (num_req > 1) ? $clog2(num_req) : 1;

   // Address plus payload must fit in the packet body.
   if (ADDR_W + payload_sz > BODY_W) begin : g_bad_widths
      $error("pe_inject_arb: address+payload wider than packet body");
   end

   logic [p_sz-1:0]   pe_q, pe_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [7:0]        retry_cnt_q, retry_cnt_d;
   logic              stall_q, stall_d;
   logic [BODY_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic [31:0]       tx_count_q, tx_count_d;
   logic [31:0]       rx_count_q, rx_count_d;

   logic              out_valid;
   logic              load_en;
   logic              accept;
   logic              reject;
   logic              gnt_vld;
   logic [PTR_W-1:0]  gnt_idx;

   assign out_valid = pe_q[p_sz-1];
   assign load_en   = !out_valid || !resend;
   assign accept    = out_valid && !resend;
   assign reject    = out_valid && resend;

   // Rotating priority search: first valid requester after the last winner.
   always_comb begin
      int idx;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      for (int k = 1; k <= num_req; k++) begin
         idx = (int'(ptr_q) + k) % num_req;
         if (!gnt_vld && req_valid[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = PTR_W'(idx);
         end
      end
   end

   // Handshake back to the winner only when the slot can actually be loaded.
   always_comb begin
      req_ready = '0;
      if (!reset && load_en && gnt_vld) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   // Next-state for the injection slot, retry tracking and statistics.
   always_comb begin
      pe_d        = pe_q;
      ptr_d       = ptr_q;
      retry_cnt_d = retry_cnt_q;
      stall_d     = stall_q;
      tx_count_d  = tx_count_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      rx_count_d  = rx_count_q;

      // A rejected packet stays on the wire untouched until the network takes it.
      if (load_en) begin
         if (gnt_vld) begin
            pe_d  = {1'b1, req_data[int'(gnt_idx)*BODY_W +: BODY_W]};
            ptr_d = gnt_idx;
         end else begin
            pe_d = '0;
         end
      end

      if (accept) begin
         tx_count_d  = tx_count_q + 32'd1;
         retry_cnt_d = '0;
      end else if (reject) begin
         retry_cnt_d = (retry_cnt_q == 8'hFF) ? 8'hFF : retry_cnt_q + 8'd1;
         if (int'(retry_cnt_d) >= max_retry) begin
            stall_d = 1'b1;
         end
      end

      if (interface_pe[p_sz-1]) begin
         rx_data_d  = interface_pe[p_sz-2:0];
         rx_valid_d = 1'b1;
         rx_count_d = rx_count_q + 32'd1;
      end
   end

   // State registers; reset drops any held packet and restarts arbitration at 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         pe_q        <= '0;
         ptr_q       <= PTR_W'(num_req - 1);
         retry_cnt_q <= '0;
         stall_q     <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         tx_count_q  <= '0;
         rx_count_q  <= '0;
      end else begin
         pe_q        <= pe_d;
         ptr_q       <= ptr_d;
         retry_cnt_q <= retry_cnt_d;
         stall_q     <= stall_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         tx_count_q  <= tx_count_d;
         rx_count_q  <= rx_count_d;
      end
   end

   assign pe_interface = pe_q;
   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   assign tx_count     = tx_count_q;
   assign rx_count     = rx_count_q;
   assign stall        = stall_q;

endmodule
